sync_deglitch: RTL and testbench
================================

// Module: sync_deglitch
// PURPOSE
//   Digital glitch filter and edge detector for discrete inputs after crossing.
//   Consumes the 2-flop synchronized level from bit_sync.q (d_sync). Outputs a
//   filtered level plus single-cycle rise/fall strobes to downstream logic.
//   Counts rejected glitches for health telemetry.
//   Operates entirely in the bit_sync destination clock domain.
// PARAMETERS
//   FILTER_CNT  16  consecutive samples of a new value needed to accept it;
//                   legal range 1..65535
//   RST_LEVEL   0   value of level (and stable state) at reset
//   GCNT_W      8   width of glitch_cnt; the count saturates at 2**GCNT_W-1
// PORTS
//   clk         in   1       destination-domain clock (same clock as upstream bit_sync)
//   rst_n       in   1       asynchronous, active-low reset
//   d_sync      in   1       synchronized input level; must come from bit_sync.q, never raw
//   en          in   1       filter enable; 0 = freeze level, abort any qualification
//   glitch_clr  in   1       1-cycle strobe that zeroes glitch_cnt
//   level       out  1       filtered level
//   rise        out  1       1-cycle strobe when level goes 0->1
//   fall        out  1       1-cycle strobe when level goes 1->0
//   glitch_cnt  out  GCNT_W  saturating count of rejected transitions
// BEHAVIOUR
// - Reset (asynchronous):
//   - state = RST_LEVEL ? HI : LO; level = RST_LEVEL
//   - rise = fall = 0; qualification counter = 0; glitch_cnt = 0
// - States: LO, QHI (qualifying high), HI, QLO (qualifying low). cnt is the run-length counter.
// - LO: if en and d_sync=1:
//   - FILTER_CNT=1: go to HI, level<=1, rise<=1
//   - otherwise: go to QHI, cnt<=1
// - QHI:
//   - d_sync=1 and cnt=FILTER_CNT-1: go to HI, level<=1, rise<=1, cnt<=0
//   - d_sync=1 otherwise: cnt<=cnt+1
//   - d_sync=0: go to LO, cnt<=0, glitch_cnt increments (saturating)
// - HI and QLO: mirror of LO and QHI with polarity inverted; acceptance sets level<=0, fall<=1.
// - Latency: level and the strobe are registered. They assert on the edge that
//   takes the FILTER_CNT-th consecutive new sample. Total from pin is
//   2 (bit_sync) + FILTER_CNT clocks.
// - rise and fall are high for exactly 1 cycle, never together, and only coincide with a level change.
// - en=0: QHI->LO and QLO->HI with no glitch count; cnt<=0; level holds; no strobes.
//   LO/HI hold. Qualification restarts from cnt=1 once en returns.
// - glitch_cnt saturates at all-ones and never wraps.
// - glitch_clr has priority: clear in the same cycle as an increment gives 0.
// - d_sync changing every cycle: no level change; one glitch per aborted qualification.
// - cnt width is clog2(FILTER_CNT)+1. It never exceeds FILTER_CNT-1.
// - Reset asserted mid-qualification: immediate return to reset state, no strobe.
// TESTING
// - FILTER_CNT=4, d_sync 0->1 held 10 clk -> rise on the 4th sampling edge;
//   level=1 from then on; glitch_cnt=0.
// - d_sync high for 3 clk, then low -> level stays 0, no rise, glitch_cnt=1;
//   repeat 300x with GCNT_W=8 -> glitch_cnt=255.
// - FILTER_CNT=1, d_sync toggles each clk -> level follows with 1-clk lag;
//   rise/fall alternate; glitch_cnt=0.
// - en=0 after 2 high samples, hold 5 clk, en=1 with d_sync high
//   -> rise 4 clk after en returns; glitch_cnt=0.
// - glitch_clr coincident with a rejected glitch at glitch_cnt=7 -> glitch_cnt=0.
// - rst_n low during QLO with RST_LEVEL=1 -> level=1, no fall, glitch_cnt=0, state HI.

Source files
------------

// File: rtl/sync_deglitch.sv
// Run-length glitch filter with registered rise/fall strobes and a saturating
// count of rejected transitions, for an already-synchronized discrete input.
module sync_deglitch #(
    parameter int FILTER_CNT = 16,
    parameter bit RST_LEVEL  = 1'b0,
    parameter int GCNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_sync,
    input  logic              en,
    input  logic              glitch_clr,
    output logic              level,
    output logic              rise,
    output logic              fall,
    output logic [GCNT_W-1:0] glitch_cnt
);

    localparam int                CNT_W    = $clog2(FILTER_CNT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_CNT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [GCNT_W-1:0] GCNT_MAX = '1;
    localparam logic [GCNT_W-1:0] GCNT_ONE = GCNT_W'(1);

    typedef enum logic [1:0] {
        LO  = 2'd0,
        QHI = 2'd1,
        HI  = 2'd2,
        QLO = 2'd3
    } state_t;

    localparam state_t RST_STATE = RST_LEVEL ? HI : LO;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              level_reg, level_next;
    logic              rise_reg, rise_next;
    logic              fall_reg, fall_next;
    logic [GCNT_W-1:0] glitch_cnt_reg, glitch_cnt_next;
    logic              glitch_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RST_STATE;
            cnt_reg        <= '0;
            level_reg      <= RST_LEVEL;
            rise_reg       <= 1'b0;
            fall_reg       <= 1'b0;
            glitch_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            level_reg      <= level_next;
            rise_reg       <= rise_next;
            fall_reg       <= fall_next;
            glitch_cnt_reg <= glitch_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        glitch_hit = 1'b0;

        case (state_reg)
            LO: begin
                if (en && d_sync) begin
                    if (FILTER_CNT == 1) begin
                        state_next = HI;
                        level_next = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = QHI;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            QHI: begin
                // Disabling aborts qualification silently; only a real reversal counts as a glitch.
                if (!en) begin
                    state_next = LO;
                    cnt_next   = '0;
                end else if (d_sync) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next = HI;
                        level_next = 1'b1;
                        rise_next  = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end else begin
                    state_next = LO;
                    cnt_next   = '0;
                    glitch_hit = 1'b1;
                end
            end
            HI: begin
                if (en && !d_sync) begin
                    if (FILTER_CNT == 1) begin
                        state_next = LO;
                        level_next = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        state_next = QLO;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            QLO: begin
                if (!en) begin
                    state_next = HI;
                    cnt_next   = '0;
                end else if (!d_sync) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next = LO;
                        level_next = 1'b0;
                        fall_next  = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end else begin
                    state_next = HI;
                    cnt_next   = '0;
                    glitch_hit = 1'b1;
                end
            end
            default: begin
                state_next = RST_STATE;
                cnt_next   = '0;
            end
        endcase
    end

    // Clear wins over a simultaneous rejection; the count sticks at all-ones.
    always_comb begin
        glitch_cnt_next = glitch_cnt_reg;
        if (glitch_clr) begin
            glitch_cnt_next = '0;
        end else if (glitch_hit && (glitch_cnt_reg != GCNT_MAX)) begin
            glitch_cnt_next = glitch_cnt_reg + GCNT_ONE;
        end
    end

    assign level      = level_reg;
    assign rise       = rise_reg;
    assign fall       = fall_reg;
    assign glitch_cnt = glitch_cnt_reg;

endmodule

// File: tb/tb_sync_deglitch.sv
// Bench for sync_deglitch: three instances (FILTER_CNT=4, FILTER_CNT=1, RST_LEVEL=1)
// driven from a vector table with a scoreboard queue plus hand-written corner sequences.
module tb_sync_deglitch;

    typedef struct {
        logic       d;
        logic       en;
        logic       clr;
        logic       lvl;
        logic       rise;
        logic       fall;
        logic [7:0] gc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       d4, en4, clr4, lvl4, rise4, fall4;
    logic [7:0] gc4;
    logic       d1, en1, clr1, lvl1, rise1, fall1;
    logic [7:0] gc1;
    logic       dh, enh, clrh, lvlh, riseh, fallh;
    logic [7:0] gch;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    sync_deglitch #(.FILTER_CNT(4), .RST_LEVEL(1'b0), .GCNT_W(8)) u_f4 (
        .clk(clk), .rst_n(rst_n), .d_sync(d4), .en(en4), .glitch_clr(clr4),
        .level(lvl4), .rise(rise4), .fall(fall4), .glitch_cnt(gc4)
    );

    sync_deglitch #(.FILTER_CNT(1), .RST_LEVEL(1'b0), .GCNT_W(8)) u_f1 (
        .clk(clk), .rst_n(rst_n), .d_sync(d1), .en(en1), .glitch_clr(clr1),
        .level(lvl1), .rise(rise1), .fall(fall1), .glitch_cnt(gc1)
    );

    sync_deglitch #(.FILTER_CNT(4), .RST_LEVEL(1'b1), .GCNT_W(8)) u_hi (
        .clk(clk), .rst_n(rst_n), .d_sync(dh), .en(enh), .glitch_clr(clrh),
        .level(lvlh), .rise(riseh), .fall(fallh), .glitch_cnt(gch)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input logic d, input logic en, input logic clr,
                       input logic l, input logic r, input logic f, input logic [7:0] g);
        vec_t v;
        v.d = d; v.en = en; v.clr = clr; v.lvl = l; v.rise = r; v.fall = f; v.gc = g;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    initial begin
        vec_t e;
        rst_n = 1'b0;
        d4 = 0; en4 = 1; clr4 = 0;
        d1 = 0; en1 = 1; clr1 = 0;
        dh = 1; enh = 1; clrh = 0;

        // FILTER_CNT=4 expectations, one record per clock edge: outputs after that edge.
        add(3, 1, 1, 0, 0, 0, 0, 8'd0);   // qualifying high
        add(1, 1, 1, 0, 1, 1, 0, 8'd0);   // 4th sample accepted
        add(6, 1, 1, 0, 1, 0, 0, 8'd0);
        add(3, 0, 1, 0, 1, 0, 0, 8'd0);   // qualifying low
        add(1, 0, 1, 0, 0, 0, 1, 8'd0);
        add(1, 0, 1, 0, 0, 0, 0, 8'd0);
        add(3, 1, 1, 0, 0, 0, 0, 8'd0);   // three highs then drop -> glitch
        add(1, 0, 1, 0, 0, 0, 0, 8'd1);
        add(1, 0, 1, 0, 0, 0, 0, 8'd1);
        add(2, 1, 1, 0, 0, 0, 0, 8'd1);   // two highs, then disable
        add(5, 1, 0, 0, 0, 0, 0, 8'd1);
        add(3, 1, 1, 0, 0, 0, 0, 8'd1);   // restart from cnt=1
        add(1, 1, 1, 0, 1, 1, 0, 8'd1);
        add(1, 1, 1, 1, 1, 0, 0, 8'd0);   // clear
        add(1, 1, 1, 0, 1, 0, 0, 8'd0);

        @(posedge clk);
        #1;
        chk1("rst lvl4", lvl4, 1'b0);
        chk1("rst rise4", rise4, 1'b0);
        chk1("rst fall4", fall4, 1'b0);
        chk8("rst gc4", gc4, 8'd0);
        chk1("rst lvlh", lvlh, 1'b1);
        chk1("rst fallh", fallh, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            d4 = tbl[i].d; en4 = tbl[i].en; clr4 = tbl[i].clr;
            sb.push_back(tbl[i]);
            tick();
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL vec%0d: scoreboard empty, got 1 entry expected", i);
            end else begin
                e = sb.pop_front();
                chk1($sformatf("vec%0d lvl", i), lvl4, e.lvl);
                chk1($sformatf("vec%0d rise", i), rise4, e.rise);
                chk1($sformatf("vec%0d fall", i), fall4, e.fall);
                chk8($sformatf("vec%0d gc", i), gc4, e.gc);
            end
        end
        clr4 = 0;

        // Seven one-sample low glitches while high.
        for (int g = 0; g < 7; g++) begin
            d4 = 0; tick();
            chk1($sformatf("glitch%0d fall", g), fall4, 1'b0);
            d4 = 1; tick();
        end
        chk8("gc4 after 7", gc4, 8'd7);
        chk1("lvl4 after 7", lvl4, 1'b1);

        d4 = 0; tick();
        d4 = 1; clr4 = 1; tick();
        clr4 = 0;
        chk8("clr beats inc", gc4, 8'd0);

        for (int g = 0; g < 300; g++) begin
            d4 = 0; tick();
            d4 = 1; tick();
            if (g == 254) chk8("gc4 at 255", gc4, 8'd255);
        end
        chk8("gc4 saturated", gc4, 8'd255);
        chk1("lvl4 after 300", lvl4, 1'b1);

        // FILTER_CNT=1: level follows input with one clock of lag.
        for (int t = 0; t < 12; t++) begin
            d1 = (t % 2 == 0);
            tick();
            chk1($sformatf("f1 t%0d lvl", t), lvl1, d1);
            chk1($sformatf("f1 t%0d rise", t), rise1, d1);
            chk1($sformatf("f1 t%0d fall", t), fall1, ~d1);
        end
        chk8("f1 gc", gc1, 8'd0);

        // RST_LEVEL=1 instance: log one glitch, then reset mid-qualification low.
        dh = 0; tick();
        dh = 1; tick();
        chk8("hi gc before rst", gch, 8'd1);
        dh = 0; tick(); tick();
        chk1("hi qlo lvl", lvlh, 1'b1);
        chk1("hi qlo fall", fallh, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("hi rst lvl", lvlh, 1'b1);
        chk1("hi rst fall", fallh, 1'b0);
        chk8("hi rst gc", gch, 8'd0);
        dh = 1;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        chk8("hi gc after rst", gch, 8'd0);
        chk1("hi lvl after rst", lvlh, 1'b1);
        dh = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk1($sformatf("hi requal t%0d fall", t), fallh, 1'b0);
        end
        tick();
        chk1("hi requal fall", fallh, 1'b1);
        chk1("hi requal lvl", lvlh, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
